// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/pause control, a
// one-cycle done pulse at terminal count and optional automatic reload.
// Load values above MAX_VAL are clamped and flagged with a load_err pulse.
module countdown_timer #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_load_err;
    logic             w_load_err_nxt;

    // State, count, reload value and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= ZERO_W;
            r_reload   <= ZERO_W;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // Next state and next count/reload; load beats start, start beats pause.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (load) begin
            // Load always returns to IDLE, aborting any run in progress.
            if (data_in > MAX_W) begin
                w_count_nxt    = MAX_W;
                w_reload_nxt   = MAX_W;
                w_load_err_nxt = 1'b1;
            end else begin
                w_count_nxt    = data_in;
                w_reload_nxt   = data_in;
                w_load_err_nxt = 1'b0;
            end
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Starting from zero has nothing to count: report done at once.
                        if (r_count == ZERO_W) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_count_nxt = r_count;
                    end else if (r_count > ONE_W) begin
                        w_count_nxt = r_count - ONE_W;
                    end else if (r_count == ONE_W) begin
                        w_done_nxt = 1'b1;
                        if (auto_reload && (r_reload != ZERO_W)) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = ZERO_W;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        // RUN with a zero count cannot arise; fall back to IDLE.
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = ZERO_W;
                end
            endcase
        end
    end

    // Registered busy mirrors the state being entered on this edge.
    always_comb begin
        if (w_state_nxt == ST_RUN) begin
            w_busy_nxt = 1'b1;
        end else begin
            w_busy_nxt = 1'b0;
        end
    end

    assign data_out = r_count;
    assign busy     = r_busy;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a behavioural model predicts each edge's outputs,
// pushes them to a queue at drive time, and a monitor compares after the edge.
module tb_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] data_in;
    logic       start;
    logic       pause;
    logic       auto_reload;
    logic [3:0] data_out;
    logic       busy;
    logic       done;
    logic       load_err;

    int total;
    int bad;
    int done_exp_cnt;
    int done_seen_cnt;

    // expected = {data_out[3:0], busy, done, load_err}
    logic [6:0] exp_q[$];

    logic [3:0] m_count;
    logic [3:0] m_reload;
    logic       m_run;

    countdown_timer #(.WIDTH(4), .MAX_VAL(13)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .start      (start),
        .pause      (pause),
        .auto_reload(auto_reload),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the prediction.
    task automatic step(input logic rst, input logic ld, input logic [3:0] din,
                        input logic st, input logic ps, input logic ar);
        logic e_done;
        logic e_err;
        @(negedge clk);
        reset       = rst;
        load        = ld;
        data_in     = din;
        start       = st;
        pause       = ps;
        auto_reload = ar;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_count  = 4'd0;
            m_reload = 4'd0;
            m_run    = 1'b0;
        end else if (ld) begin
            if (din > 4'd13) begin
                m_count = 4'd13;
                e_err   = 1'b1;
            end else begin
                m_count = din;
            end
            m_reload = m_count;
            m_run    = 1'b0;
        end else if (!m_run) begin
            if (st) begin
                if (m_count == 4'd0) e_done = 1'b1;
                else m_run = 1'b1;
            end
        end else if (ps) begin
            m_count = m_count;
        end else if (m_count == 4'd1) begin
            e_done = 1'b1;
            if (ar && (m_reload != 4'd0)) begin
                m_count = m_reload;
            end else begin
                m_count = 4'd0;
                m_run   = 1'b0;
            end
        end else begin
            m_count = m_count - 4'd1;
        end
        if (e_done) done_exp_cnt = done_exp_cnt + 1;
        exp_q.push_back({m_count, m_run, e_done, e_err});
    endtask

    task automatic idle(input int n, input logic ar);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ar);
    endtask

    // Monitor: compare DUT outputs just after each rising edge.
    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("data_out", {28'd0, data_out}, {28'd0, e[6:3]});
            check_val("busy",     {31'd0, busy},     {31'd0, e[2]});
            check_val("done",     {31'd0, done},     {31'd0, e[1]});
            check_val("load_err", {31'd0, load_err}, {31'd0, e[0]});
            if (done === 1'b1) done_seen_cnt = done_seen_cnt + 1;
        end
    end

    initial begin
        total = 0;
        bad = 0;
        done_exp_cnt = 0;
        done_seen_cnt = 0;
        m_count = 4'd0;
        m_reload = 4'd0;
        m_run = 1'b0;
        reset = 1'b1;
        load = 1'b0;
        data_in = 4'd0;
        start = 1'b0;
        pause = 1'b0;
        auto_reload = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Zero start: done pulse only
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Basic countdown from 5
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(7, 1'b0);

        // Clamp and exact-max load
        step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Auto-reload at 3, then release auto_reload
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(8, 1'b1);
        idle(5, 1'b0);

        // Auto-reload at 1: done every cycle
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Pause at 4 for two cycles, start asserted during pause is ignored
        step(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b0);

        // Load together with start: load wins
        step(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Load mid-run aborts
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Reset mid-run at count 5, then start gives done only
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Reset on the terminal edge suppresses done
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 11) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1));
        end
        idle(2, 1'b0);

        // Let the last prediction be consumed, bounded wait
        repeat (2) @(posedge clk);
        #2;
        check_val("queue_drain", exp_q.size(), 32'd0);
        check_val("done_count", done_seen_cnt, done_exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter, the complement to the team's mod-14 loadable up-counter.
- Holds a programmable start value and counts it down to zero under a start/pause control interface.
- Asserts a one-cycle done pulse at terminal count, with optional automatic reload for periodic operation.
- Used as a timeout/interval generator beside the up-counter in the counter verification environment.

Parameters:
- WIDTH, 4, bit width of count and load value.
- MAX_VAL, 13, largest legal load value; larger values are clamped to it.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load data_in into count and reload register.
- data_in  input  WIDTH  value to load.
- start  input  1  begin counting (IDLE only).
- pause  input  1  hold count while running.
- auto_reload  input  1  on terminal count, reload and keep running.
- data_out  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, terminal count reached.
- load_err  output  1  one-cycle pulse, load value was clamped.

Behaviour:
- Single clock domain. reset is synchronous and active-high, and is sampled only on the rising edge of clk.
- Reset values: data_out=0, reload register=0, busy=0, done=0, load_err=0, state=IDLE.
- Reset mid-operation:
  - Aborts immediately at the next edge.
  - The pending done is not issued.
- States: IDLE, RUN. busy=1 exactly when state=RUN. All outputs are registered.
- Priority per edge: reset > load > start > pause > decrement.
- load (any state):
  - count <= min(data_in, MAX_VAL); reload register gets the same value.
  - If data_in > MAX_VAL, load_err=1 for one cycle.
  - Next state is IDLE; load aborts a run and busy drops. done=0 on that edge.
- start:
  - In IDLE with count!=0: go to RUN with no change to count. The first decrement happens on the following edge.
  - In IDLE with count==0: stay in IDLE, done=1 for one cycle.
  - In RUN: ignored.
  - Same edge as load: load wins and start is ignored.
- RUN with pause=1: count holds, state stays RUN, busy stays 1, done=0.
- RUN with pause=0 and count>1: count <= count-1.
- RUN with pause=0 and count==1 (terminal):
  - done=1 on this edge.
  - If auto_reload=1 and reload register !=0: count <= reload register, stay in RUN.
  - Otherwise: count <= 0, go to IDLE, busy=0 on the same edge.
- Latency: load at edge N, start at edge N+1 → data_out reaches 0 and done asserts at edge N+1+L, for loaded value L. With auto_reload, done repeats every L cycles, excluding paused cycles.
- done and load_err are never high for more than one consecutive cycle, except that done repeats each cycle when auto_reload=1 and reload=1.
- Count arithmetic is unsigned WIDTH-bit. Decrement never occurs from 0, so no underflow wrap.
- auto_reload is sampled only at terminal count and may change freely otherwise.

Test Plan:
- Basic countdown: load 5, start → RUN entered with data_out=5; then 4,3,2,1,0 on consecutive edges. done=1 only on the edge data_out becomes 0, and busy falls on that same edge.
- Clamp: load with data_in=15 → data_out=13, load_err=1 for one cycle. Load with data_in=13 → load_err=0.
- Auto-reload: auto_reload=1, load 3, start → data_out 3,2,1,3,2,1,3… with done pulsing every 3rd cycle. Clear auto_reload → after the next terminal count data_out=0, busy=0.
- Pause and priority: load 6, start, count to 4, pause for 2 cycles → data_out holds 4 with busy=1, then resumes 3,2,1,0. Load 9 asserted together with start → data_out=9, state IDLE, busy=0.
- Zero start: after reset (count 0), pulse start → done=1 for one cycle, busy stays 0, data_out stays 0.
- Reset mid-run: load 8, start, reset asserted at count 5 → next edge data_out=0, busy=0, done=0. A later start → done pulse only, no countdown.
